rf_mp_sb: RTL
=============

// Module: rf_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file for the core datapath: NUM_RD async read
//  ports, two sync write ports, hardwired-zero x0, per-register pending scoreboard and a
//  sequential clear engine. Sits between decode (reads, alloc) and writeback (writes).
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   address width; depth = 2**ADDR_W registers
//  NUM_RD  2   number of read ports (1..4)
// PORTS
//  clk_i      in   1               clock, all state updates on rising edge
//  reset      in   1               sync, active-high; zeros all regs, pending bits, FSM->IDLE
//  ra_i       in   NUM_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_o       out  NUM_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
//  pend_o     out  NUM_RD          pending bit of register addressed by ra_i port k
//  we_i       in   2               write enables, ports 0 and 1
//  wa_i       in   2*ADDR_W        write addresses
//  wd_i       in   2*DATA_W        write data
//  alloc_i    in   1               mark register alloc_a_i as pending (producer issued)
//  alloc_a_i  in   ADDR_W          allocation address
//  clr_i      in   1               start sequential clear of all registers
//  busy_o     out  1               clear engine active; writes/allocs ignored
// BEHAVIOUR
//  - Reset: all regs 0, all pending 0, FSM IDLE, busy_o 0; rd_o/pend_o then read 0.
//  - Reads combinational, 0-cycle latency. Address 0 always reads 0, pend 0.
//  - Writes take effect at the clock edge; visible on rd_o the following cycle.
//  - Writes to address 0 discarded. Both ports same nonzero address: port 1 wins.
//  - Write on either port clears pending bit of its address at the same edge.
//  - alloc_i sets pending[alloc_a_i] (ignored for 0). Alloc and write same address same
//    cycle: pending ends 1 (new producer wins); data still written.
//  - FSM IDLE: clr_i=1 -> CLEAR, counter=0, busy_o=1 from next cycle.
//  - FSM CLEAR: each cycle reg[counter]<=0 and pending[counter]<=0, counter++;
//    after counter==2**ADDR_W-1 cleared -> IDLE, busy_o=0 next cycle. Takes 2**ADDR_W cycles.
//  - During CLEAR: we_i, alloc_i, clr_i ignored; reads stay live (uncleared regs keep data).
//  - clr_i asserted together with writes in IDLE: writes in that cycle are performed.
//  - reset overrides everything, including mid-CLEAR: immediate full zero, FSM IDLE.
//  - Counter ADDR_W bits wide; terminal detection by all-ones, no wrap beyond.
// CONFIGURATION
//  RF_BYPASS_EN defined: read port whose address equals an enabled nonzero write address
//   returns that write data same cycle (port 1 priority), and pend_o reads 0 for it.
//  RF_BYPASS_EN undefined: reads return stored value until the edge; no forwarding.
//  Bypass inactive while busy_o=1 (writes ignored).
// TESTING
//  1. reset 1 cycle; read ra=0..31 -> rd_o=0, pend_o=0, busy_o=0.
//  2. we0 wa=5 wd=0xDEADBEEF; next cycle ra0=5 -> 0xDEADBEEF; we0 wa=0 wd=1 -> ra=0 reads 0.
//  3. we0/we1 both wa=7, wd 0x11/0x22 -> reg7=0x22; alloc 9 then we1 wa=9 -> pend 1 then 0.
//  4. same-cycle we0 wa=3 wd=0x55, ra0=3: bypass build -> 0x55 same cycle; else old value.
//  5. fill regs, pulse clr_i -> busy_o high 32 cycles, writes ignored, then all regs 0.
//  6. reset asserted at CLEAR cycle 10 -> next cycle busy_o=0, all regs and pending 0.

Source files
------------

// File: rtl/rf_mp_sb.sv
// Multi-port integer register file: async reads, two sync write ports, hardwired x0,
// per-register pending scoreboard and sequential clear engine. Optional RF_BYPASS_EN forwarding.
module rf_mp_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] ra_i,
  output logic [NUM_RD*DATA_W-1:0] rd_o,
  output logic [NUM_RD-1:0]        pend_o,
  input  logic [1:0]               we_i,
  input  logic [2*ADDR_W-1:0]      wa_i,
  input  logic [2*DATA_W-1:0]      wd_i,
  input  logic                     alloc_i,
  input  logic [ADDR_W-1:0]        alloc_a_i,
  input  logic                     clr_i,
  output logic                     busy_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]    pend_q;
  logic [ADDR_W-1:0]   cnt_q;

  logic [ADDR_W-1:0]   wa0, wa1;
  logic [DATA_W-1:0]   wd0, wd1;
  logic                wr0, wr1;

  assign wa0 = wa_i[ADDR_W-1:0];
  assign wa1 = wa_i[2*ADDR_W-1:ADDR_W];
  assign wd0 = wd_i[DATA_W-1:0];
  assign wd1 = wd_i[2*DATA_W-1:DATA_W];
  assign wr0 = we_i[0] && (wa0 != '0) && !busy_o;
  assign wr1 = we_i[1] && (wa1 != '0) && !busy_o;

  always_ff @(posedge clk_i) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_i) state_d = CLEAR;
      CLEAR:   if (cnt_q == '1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == CLEAR);
  end

  // Port 1 assigned after port 0 so it wins on collision; alloc last so a new producer wins.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else if (busy_o) begin
      regs_q[cnt_q] <= '0;
      pend_q[cnt_q] <= 1'b0;
      cnt_q         <= cnt_q + ADDR_W'(1);
    end else begin
      if (wr0) begin
        regs_q[wa0] <= wd0;
        pend_q[wa0] <= 1'b0;
      end
      if (wr1) begin
        regs_q[wa1] <= wd1;
        pend_q[wa1] <= 1'b0;
      end
      if (alloc_i && (alloc_a_i != '0)) pend_q[alloc_a_i] <= 1'b1;
      if (clr_i) cnt_q <= '0;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = ra_i[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_o[k*DATA_W +: DATA_W] = '0;
      pend_o[k]                = 1'b0;
      if (a != '0) begin
        rd_o[k*DATA_W +: DATA_W] = regs_q[a];
        pend_o[k]                = pend_q[a];
`ifdef RF_BYPASS_EN
        if (wr1 && (wa1 == a)) begin
          rd_o[k*DATA_W +: DATA_W] = wd1;
          pend_o[k]                = 1'b0;
        end else if (wr0 && (wa0 == a)) begin
          rd_o[k*DATA_W +: DATA_W] = wd0;
          pend_o[k]                = 1'b0;
        end
`endif
      end
    end
  end

endmodule
